// File: rtl/pf_ddr4_bclk_trn_pkg.sv
// Shared types and constants for the BCLK training controller and its tap classifier.
package pf_ddr4_bclk_trn_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_CLEAR,
    S_CLEAR_GAP,
    S_SAMPLE,
    S_EVAL,
    S_STEP,
    S_PARK_LOAD,
    S_PARK_SETTLE,
    S_PARK_STEP,
    S_DONE,
    S_FAIL
  } state_e;

  typedef enum logic [1:0] {
    PH_SEEK_STABLE,
    PH_SEEK_EDGE,
    PH_IN_EDGE
  } phase_e;

  localparam logic [7:0] STABLE_LO = 8'h00;
  localparam logic [7:0] STABLE_HI = 8'hFF;

  function automatic logic is_busy(input state_e s);
    return !(s inside {S_IDLE, S_DONE, S_FAIL});
  endfunction

endpackage

// File: rtl/pf_ddr4_bclk_tap_classifier.sv
// Watches RX_DATA and the eye-monitor flags over one sample window and decides
// whether the current tap sits in the BCLK transition region (noisy) or not.
module pf_ddr4_bclk_tap_classifier
  import pf_ddr4_bclk_trn_pkg::*;
#(
  parameter int SAMPLE_CYCLES = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       sample_en_i,
  input  logic [7:0] rx_data_i,
  input  logic       early_i,
  input  logic       late_i,
  output logic       valid_o,
  output logic       noisy_o
);

  localparam int CNT_W = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       w0_q, w0_d;
  logic             acc_q, acc_d;

  logic       first, last, hit;
  logic [7:0] w0_ref;

  assign first  = (cnt_q == '0);
  assign last   = (cnt_q == CNT_LAST);
  // On the first window cycle the live word is W0, so compare against itself.
  assign w0_ref = first ? rx_data_i : w0_q;
  assign hit    = (rx_data_i != w0_ref) | early_i | late_i |
                  (first & (rx_data_i != STABLE_LO) & (rx_data_i != STABLE_HI));

  assign valid_o = sample_en_i & last;
  assign noisy_o = (~first & acc_q) | hit;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    cnt_d = '0;
    w0_d  = w0_q;
    acc_d = acc_q;
    if (sample_en_i) begin
      cnt_d = last ? '0 : cnt_q + 1'b1;
      acc_d = first ? hit : (acc_q | hit);
      if (first) w0_d = rx_data_i;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      w0_q  <= '0;
      acc_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      w0_q  <= w0_d;
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/pf_ddr4_bclk_training_ctrl.sv
// BCLK delay-line training: sweeps taps, finds the transition region, parks
// the delay line on its centre tap. All IOD-facing controls are registered.
module pf_ddr4_bclk_training_ctrl
  import pf_ddr4_bclk_trn_pkg::*;
#(
  parameter int TAP_W         = 8,
  parameter int MAX_TAPS      = 255,
  parameter int SETTLE_CYCLES = 4,
  parameter int SAMPLE_CYCLES = 16
) (
  input  logic             FAB_CLK,
  input  logic             ARST,
  input  logic             START,
  input  logic [7:0]       RX_DATA,
  input  logic             EYE_MONITOR_EARLY,
  input  logic             EYE_MONITOR_LATE,
  input  logic             DELAY_LINE_OUT_OF_RANGE,
  output logic             DELAY_LINE_LOAD,
  output logic             DELAY_LINE_MOVE,
  output logic             DELAY_LINE_DIRECTION,
  output logic             EYE_MONITOR_CLEAR_FLAGS,
  output logic             ODT_EN,
  output logic             BUSY,
  output logic             DONE,
  output logic             FAIL,
  output logic [TAP_W-1:0] EDGE0,
  output logic [TAP_W-1:0] EDGE1,
  output logic [TAP_W-1:0] FINAL_TAP
);

  localparam int               TMR_W      = $clog2(SETTLE_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TAP_W-1:0] TAP_LAST   = TAP_W'(MAX_TAPS);

  state_e            state_q, state_d;
  phase_e            phase_q, phase_d;
  logic [TAP_W-1:0]  tap_q, tap_d;
  logic [TAP_W-1:0]  edge0_q, edge0_d;
  logic [TAP_W-1:0]  edge1_q, edge1_d;
  logic [TAP_W-1:0]  final_q, final_d;
  logic [TAP_W-1:0]  park_q, park_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic              noisy_q, noisy_d;

  logic load_q, move_q, clear_q, dir_q, odt_q, busy_q, done_q, fail_q;

  logic             cls_valid, cls_noisy;
  logic             end_sweep, park_now;
  logic [TAP_W:0]   edge_sum;
  logic [TAP_W-1:0] mid_tap;

  pf_ddr4_bclk_tap_classifier #(
    .SAMPLE_CYCLES(SAMPLE_CYCLES)
  ) u_classifier (
    .clk_i      (FAB_CLK),
    .rst_i      (ARST),
    .sample_en_i(state_q == S_SAMPLE),
    .rx_data_i  (RX_DATA),
    .early_i    (EYE_MONITOR_EARLY),
    .late_i     (EYE_MONITOR_LATE),
    .valid_o    (cls_valid),
    .noisy_o    (cls_noisy)
  );

  // Sum is one bit wider so taps near the top of the range cannot overflow.
  assign edge_sum  = {1'b0, edge0_q} + {1'b0, edge1_q};
  assign mid_tap   = TAP_W'(edge_sum >> 1);
  assign end_sweep = (tap_q == TAP_LAST) | DELAY_LINE_OUT_OF_RANGE;

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    tap_d    = tap_q;
    edge0_d  = edge0_q;
    edge1_d  = edge1_q;
    final_d  = final_q;
    park_d   = park_q;
    timer_d  = timer_q;
    noisy_d  = noisy_q;
    park_now = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE, S_FAIL: if (START) state_d = S_LOAD;
      S_LOAD: begin
        tap_d   = '0;
        edge0_d = '0;
        edge1_d = '0;
        final_d = '0;
        phase_d = PH_SEEK_STABLE;
        timer_d = TMR_RELOAD;
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (timer_q == '0) state_d = S_CLEAR;
        else               timer_d = timer_q - 1'b1;
      end
      S_CLEAR:     state_d = S_CLEAR_GAP;
      S_CLEAR_GAP: state_d = S_SAMPLE;
      S_SAMPLE: begin
        if (cls_valid) begin
          noisy_d = cls_noisy;
          state_d = S_EVAL;
        end
      end
      S_EVAL: begin
        unique case (phase_q)
          PH_SEEK_STABLE: if (!noisy_q) phase_d = PH_SEEK_EDGE;
          PH_SEEK_EDGE: begin
            if (noisy_q) begin
              edge0_d = tap_q;
              edge1_d = tap_q;
              phase_d = PH_IN_EDGE;
            end
          end
          default: begin
            if (noisy_q) edge1_d  = tap_q;
            else         park_now = 1'b1;
          end
        endcase
        // An edge still open at the end stop is parked on as-is.
        if (park_now || (end_sweep && phase_d == PH_IN_EDGE)) begin
          state_d = S_PARK_LOAD;
        end else if (end_sweep) begin
          edge0_d = '0;
          edge1_d = '0;
          final_d = '0;
          state_d = S_FAIL;
        end else begin
          state_d = S_STEP;
        end
      end
      S_STEP: begin
        tap_d   = tap_q + 1'b1;
        timer_d = TMR_RELOAD;
        state_d = S_SETTLE;
      end
      S_PARK_LOAD: begin
        final_d = mid_tap;
        park_d  = mid_tap;
        timer_d = TMR_RELOAD;
        state_d = S_PARK_SETTLE;
      end
      S_PARK_SETTLE: begin
        if (timer_q != '0)    timer_d = timer_q - 1'b1;
        else if (park_q == '0) state_d = S_DONE;
        else                  state_d = S_PARK_STEP;
      end
      S_PARK_STEP: begin
        park_d  = park_q - 1'b1;
        timer_d = TMR_RELOAD;
        state_d = S_PARK_SETTLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge FAB_CLK or posedge ARST) begin
    if (ARST) begin
      state_q <= S_IDLE;
      phase_q <= PH_SEEK_STABLE;
      tap_q   <= '0;
      edge0_q <= '0;
      edge1_q <= '0;
      final_q <= '0;
      park_q  <= '0;
      timer_q <= '0;
      noisy_q <= 1'b0;
      load_q  <= 1'b0;
      move_q  <= 1'b0;
      clear_q <= 1'b0;
      dir_q   <= 1'b0;
      odt_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      tap_q   <= tap_d;
      edge0_q <= edge0_d;
      edge1_q <= edge1_d;
      final_q <= final_d;
      park_q  <= park_d;
      timer_q <= timer_d;
      noisy_q <= noisy_d;
      // Pulses decode the next state so each one lines up with its state cycle.
      load_q  <= (state_d == S_LOAD) || (state_d == S_PARK_LOAD);
      move_q  <= (state_d == S_STEP) || (state_d == S_PARK_STEP);
      clear_q <= (state_d == S_CLEAR);
      dir_q   <= is_busy(state_d);
      odt_q   <= is_busy(state_d);
      busy_q  <= is_busy(state_d);
      done_q  <= (state_d == S_DONE);
      fail_q  <= (state_d == S_FAIL);
    end
  end

  assign DELAY_LINE_LOAD         = load_q;
  assign DELAY_LINE_MOVE         = move_q;
  assign DELAY_LINE_DIRECTION    = dir_q;
  assign EYE_MONITOR_CLEAR_FLAGS = clear_q;
  assign ODT_EN                  = odt_q;
  assign BUSY                    = busy_q;
  assign DONE                    = done_q;
  assign FAIL                    = fail_q;
  assign EDGE0                   = edge0_q;
  assign EDGE1                   = edge1_q;
  assign FINAL_TAP               = final_q;

endmodule

// File: tb/tb_pf_ddr4_bclk_training_ctrl.sv
// Directed bench: IOD lane model, pulse-protocol monitor and one task per scenario.
module tb_pf_ddr4_bclk_training_ctrl;

  localparam int SETTLE_CYCLES = 4;
  localparam int BUDGET        = 20000;

  logic       FAB_CLK = 1'b0;
  logic       ARST    = 1'b1;
  logic       START   = 1'b0;
  logic [7:0] RX_DATA;
  logic       EYE_MONITOR_EARLY, EYE_MONITOR_LATE, DELAY_LINE_OUT_OF_RANGE;
  logic       DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION, EYE_MONITOR_CLEAR_FLAGS;
  logic       ODT_EN, BUSY, DONE, FAIL;
  logic [7:0] EDGE0, EDGE1, FINAL_TAP;

  int vectors     = 0;
  int miscompares = 0;

  // IOD lane model state
  int         pattern   = 1;
  int         model_tap = 0;
  logic [7:0] cyc       = 8'h00;
  logic       early_q   = 1'b0;

  // protocol monitor state
  int   loads = 0, moves = 0, moves_since_load = 0, proto_errs = 0, gap = 100;
  logic prev_dir = 1'b0;

  pf_ddr4_bclk_training_ctrl dut (
    .FAB_CLK                (FAB_CLK),
    .ARST                   (ARST),
    .START                  (START),
    .RX_DATA                (RX_DATA),
    .EYE_MONITOR_EARLY      (EYE_MONITOR_EARLY),
    .EYE_MONITOR_LATE       (EYE_MONITOR_LATE),
    .DELAY_LINE_OUT_OF_RANGE(DELAY_LINE_OUT_OF_RANGE),
    .DELAY_LINE_LOAD        (DELAY_LINE_LOAD),
    .DELAY_LINE_MOVE        (DELAY_LINE_MOVE),
    .DELAY_LINE_DIRECTION   (DELAY_LINE_DIRECTION),
    .EYE_MONITOR_CLEAR_FLAGS(EYE_MONITOR_CLEAR_FLAGS),
    .ODT_EN                 (ODT_EN),
    .BUSY                   (BUSY),
    .DONE                   (DONE),
    .FAIL                   (FAIL),
    .EDGE0                  (EDGE0),
    .EDGE1                  (EDGE1),
    .FINAL_TAP              (FINAL_TAP)
  );

  always #5 FAB_CLK = ~FAB_CLK;

  always @(posedge FAB_CLK) begin
    cyc <= cyc + 8'd1;
    if (DELAY_LINE_LOAD)      model_tap <= 0;
    else if (DELAY_LINE_MOVE) model_tap <= DELAY_LINE_DIRECTION ? model_tap + 1 : model_tap - 1;
    if (EYE_MONITOR_CLEAR_FLAGS)           early_q <= 1'b0;
    else if (pattern == 4 && model_tap == 20) early_q <= 1'b1;
  end

  always_comb begin
    RX_DATA = 8'h00;
    case (pattern)
      1: RX_DATA = (model_tap < 10) ? 8'h00 : ((model_tap <= 13) ? (8'h3C ^ cyc) : 8'hFF);
      2: RX_DATA = 8'h5A;
      3: RX_DATA = (model_tap < 250) ? 8'h00 : (8'h3C ^ cyc);
      default: RX_DATA = 8'h00;
    endcase
  end

  assign EYE_MONITOR_EARLY       = early_q;
  assign EYE_MONITOR_LATE        = 1'b0;
  assign DELAY_LINE_OUT_OF_RANGE = (model_tap >= 255);

  always @(negedge FAB_CLK) begin
    int n;
    if (ARST) begin
      gap      = 100;
      prev_dir = 1'b0;
    end else begin
      n = int'(DELAY_LINE_LOAD) + int'(DELAY_LINE_MOVE) + int'(EYE_MONITOR_CLEAR_FLAGS);
      if (n > 1) begin
        $display("FAIL proto_overlap: %0d pulses in one cycle, required <= 1", n);
        proto_errs++;
      end
      if (n > 0) begin
        if (gap < SETTLE_CYCLES) begin
          $display("FAIL proto_gap: %0d idle cycles between pulses, required >= %0d", gap, SETTLE_CYCLES);
          proto_errs++;
        end
        gap = 0;
      end else begin
        gap++;
      end
      if (DELAY_LINE_MOVE) begin
        moves++;
        moves_since_load++;
        if (!DELAY_LINE_DIRECTION || !prev_dir) begin
          $display("FAIL proto_direction: dir before/during MOVE = %b/%b, required 1/1",
                   prev_dir, DELAY_LINE_DIRECTION);
          proto_errs++;
        end
      end
      if (DELAY_LINE_LOAD) begin
        loads++;
        moves_since_load = 0;
      end
      prev_dir = DELAY_LINE_DIRECTION;
    end
  end

  task automatic apply_start();
    @(negedge FAB_CLK);
    START = 1'b1;
    @(negedge FAB_CLK);
    START = 1'b0;
  endtask

  task automatic wait_end(input string name);
    int i;
    for (i = 0; i < BUDGET; i++) begin
      @(negedge FAB_CLK);
      if (DONE || FAIL) break;
    end
    vectors++;
    if (i >= BUDGET) begin
      $display("FAIL %s_timeout: no DONE/FAIL after %0d cycles", name, BUDGET);
      miscompares++;
    end
  endtask

  task automatic check_start(input string name);
    vectors++;
    if ({DELAY_LINE_LOAD, BUSY, ODT_EN, DONE, FAIL} !== 5'b11100) begin
      $display("FAIL %s_start: load/busy/odt/done/fail = %b, required 11100", name,
               {DELAY_LINE_LOAD, BUSY, ODT_EN, DONE, FAIL});
      miscompares++;
    end
  endtask

  task automatic check_result(input string name, input logic done_exp,
                              input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] ft);
    vectors++;
    if ({DONE, FAIL, BUSY, ODT_EN} !== {done_exp, ~done_exp, 2'b00}) begin
      $display("FAIL %s_status: done/fail/busy/odt = %b, required %b", name,
               {DONE, FAIL, BUSY, ODT_EN}, {done_exp, ~done_exp, 2'b00});
      miscompares++;
    end
    vectors++;
    if ({EDGE0, EDGE1, FINAL_TAP} !== {e0, e1, ft}) begin
      $display("FAIL %s_taps: edge0/edge1/final = %0d/%0d/%0d, required %0d/%0d/%0d", name,
               EDGE0, EDGE1, FINAL_TAP, e0, e1, ft);
      miscompares++;
    end
  endtask

  task automatic check_all_zero(input string name);
    vectors++;
    if ({DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION, EYE_MONITOR_CLEAR_FLAGS,
         ODT_EN, BUSY, DONE, FAIL, EDGE0, EDGE1, FINAL_TAP} !== 32'h0) begin
      $display("FAIL %s: outputs = %h, required all 0", name,
               {DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION, EYE_MONITOR_CLEAR_FLAGS,
                ODT_EN, BUSY, DONE, FAIL, EDGE0, EDGE1, FINAL_TAP});
      miscompares++;
    end
  endtask

  task automatic check_proto(input string name, input int errs0);
    vectors++;
    if (proto_errs !== errs0) begin
      $display("FAIL %s_protocol: %0d protocol violations, required 0", name, proto_errs - errs0);
      miscompares++;
    end
  endtask

  task automatic test_reset();
    ARST = 1'b1;
    repeat (3) @(negedge FAB_CLK);
    check_all_zero("reset_held");
    ARST = 1'b0;
    repeat (2) @(negedge FAB_CLK);
    check_all_zero("reset_idle");
  endtask

  task automatic test_edge_sweep();
    int errs0 = proto_errs, mv0 = moves;
    pattern = 1;
    apply_start();
    check_start("edge");
    wait_end("edge");
    check_result("edge", 1'b1, 8'd10, 8'd13, 8'd11);
    vectors++;
    if (moves_since_load !== 11 || moves - mv0 !== 25) begin
      $display("FAIL edge_moves: park/total = %0d/%0d, required 11/25", moves_since_load, moves - mv0);
      miscompares++;
    end
    check_proto("edge", errs0);
  endtask

  task automatic test_always_noisy();
    int errs0 = proto_errs, mv0 = moves, ld0 = loads;
    pattern = 2;
    apply_start();
    check_start("noisy");
    wait_end("noisy");
    check_result("noisy", 1'b0, 8'd0, 8'd0, 8'd0);
    vectors++;
    if (moves - mv0 !== 255 || loads - ld0 !== 1) begin
      $display("FAIL noisy_pulses: moves/loads = %0d/%0d, required 255/1", moves - mv0, loads - ld0);
      miscompares++;
    end
    check_proto("noisy", errs0);
  endtask

  task automatic test_end_stop();
    int errs0 = proto_errs;
    pattern = 3;
    apply_start();
    check_start("endstop");
    wait_end("endstop");
    check_result("endstop", 1'b1, 8'd250, 8'd255, 8'd252);
    vectors++;
    if (moves_since_load !== 252) begin
      $display("FAIL endstop_park: %0d park moves, required 252", moves_since_load);
      miscompares++;
    end
    check_proto("endstop", errs0);
  endtask

  task automatic test_early_flag();
    int errs0 = proto_errs;
    pattern = 4;
    apply_start();
    check_start("early");
    wait_end("early");
    check_result("early", 1'b1, 8'd20, 8'd20, 8'd20);
    vectors++;
    if (moves_since_load !== 20) begin
      $display("FAIL early_park: %0d park moves, required 20", moves_since_load);
      miscompares++;
    end
    check_proto("early", errs0);
  endtask

  task automatic test_back_to_back();
    int errs0 = proto_errs, ld0, i;
    pattern = 1;
    apply_start();
    for (i = 0; i < BUDGET; i++) begin
      @(negedge FAB_CLK);
      if (EYE_MONITOR_CLEAR_FLAGS && model_tap == 7) break;
    end
    vectors++;
    if (i >= BUDGET) begin
      $display("FAIL arst_reach_tap7: not reached within %0d cycles", BUDGET);
      miscompares++;
    end
    repeat (4) @(negedge FAB_CLK);
    ARST = 1'b1;
    #1;
    check_all_zero("arst_immediate");
    @(posedge FAB_CLK);
    #1;
    check_all_zero("arst_next_edge");
    @(negedge FAB_CLK);
    ARST = 1'b0;
    ld0 = loads;
    apply_start();
    check_start("retrain");
    repeat (50) @(negedge FAB_CLK);
    START = 1'b1;
    @(negedge FAB_CLK);
    START = 1'b0;
    vectors++;
    if (BUSY !== 1'b1 || DELAY_LINE_LOAD !== 1'b0) begin
      $display("FAIL busy_start: busy/load = %b/%b, required 1/0", BUSY, DELAY_LINE_LOAD);
      miscompares++;
    end
    wait_end("retrain");
    check_result("retrain", 1'b1, 8'd10, 8'd13, 8'd11);
    vectors++;
    if (loads - ld0 !== 2) begin
      $display("FAIL retrain_loads: %0d LOAD pulses, required 2", loads - ld0);
      miscompares++;
    end
    check_proto("retrain", errs0);
  endtask

  initial begin
    test_reset();
    test_edge_sweep();
    test_always_noisy();
    test_end_stop();
    test_early_flag();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
